// File: rtl/io_line_pkg.sv
// io_line_pkg: shared sizing for the CPU I/O line bridge.
//   WORD_WIDTH    - CPU datapath word width
//   DEFAULT_DEPTH - default entries per FIFO
//   ptr_width()   - read/write pointer width for a given FIFO depth
package io_line_pkg;

    localparam int WORD_WIDTH    = 16;
    localparam int DEFAULT_DEPTH = 4;

    // Depth is a power of two, so pointers wrap naturally at this width.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/io_line_fifo.sv
// io_line_fifo: synchronous FIFO used for both the TX and RX directions.
// Ports:
//   clock, resetN   - rising-edge clock, async active-low reset
//   push, pushData  - write request and word
//   pop             - read request (ignored while empty)
//   head            - oldest word, 0 when empty
//   empty, full     - occupancy flags from the registered count
// A push while full is accepted only when a pop happens in the same cycle.
module io_line_fifo
    import io_line_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_pop;
    logic w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == FULL_CNT);
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign head   = empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= pushData;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/io_line_bridge.sv
// io_line_bridge: peripheral end of the CPU inputLine/outputLine pair.
// Ports:
//   clock, resetN                 - system clock, async active-low reset
//   outputLine, outputLineWrite   - CPU word and write strobe into TX FIFO
//   txData, txValid, txReady      - TX FIFO drain to external sink
//   txFull, txOverflow            - TX full status, sticky dropped-write flag
//   rxData, rxValid, rxReady      - external source into RX FIFO
//   inputLine, inputValid         - RX FIFO head presented to the CPU
//   inputRead                     - CPU consumes inputLine
//   rxUnderflow                   - sticky read-while-empty flag
//   clearErrors                   - synchronous clear of the sticky flags
// Every output derives from registered state only.
module io_line_bridge
    import io_line_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic [WIDTH-1:0] outputLine,
    input  logic             outputLineWrite,
    input  logic             inputRead,
    output logic [WIDTH-1:0] inputLine,
    output logic             inputValid,
    output logic [WIDTH-1:0] txData,
    output logic             txValid,
    input  logic             txReady,
    input  logic [WIDTH-1:0] rxData,
    input  logic             rxValid,
    output logic             rxReady,
    output logic             txFull,
    output logic             txOverflow,
    output logic             rxUnderflow,
    input  logic             clearErrors
);

    logic w_tx_empty;
    logic w_rx_empty;
    logic w_rx_full;
    logic w_tx_pop;
    logic w_ovf;
    logic w_udf;
    logic r_txOverflow;
    logic r_rxUnderflow;

    io_line_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx (
        .clock    (clock),
        .resetN   (resetN),
        .push     (outputLineWrite),
        .pushData (outputLine),
        .pop      (txReady),
        .head     (txData),
        .empty    (w_tx_empty),
        .full     (txFull)
    );

    // RX push is gated by rxReady so the source never sees a word taken
    // while ready was low, even if the CPU pops in the same cycle.
    io_line_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx (
        .clock    (clock),
        .resetN   (resetN),
        .push     (rxValid && rxReady),
        .pushData (rxData),
        .pop      (inputRead),
        .head     (inputLine),
        .empty    (w_rx_empty),
        .full     (w_rx_full)
    );

    assign txValid    = !w_tx_empty;
    assign inputValid = !w_rx_empty;
    assign rxReady    = !w_rx_full;

    // A write against a full FIFO is only dropped if nothing drains that cycle.
    assign w_tx_pop = txValid && txReady;
    assign w_ovf    = outputLineWrite && txFull && !w_tx_pop;
    // Judged on pre-edge occupancy: a same-cycle push into an empty FIFO
    // does not rescue the read.
    assign w_udf    = inputRead && w_rx_empty;

    // New error events take priority over clearErrors.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_txOverflow  <= 1'b0;
            r_rxUnderflow <= 1'b0;
        end else begin
            r_txOverflow  <= w_ovf || (r_txOverflow  && !clearErrors);
            r_rxUnderflow <= w_udf || (r_rxUnderflow && !clearErrors);
        end
    end

    assign txOverflow  = r_txOverflow;
    assign rxUnderflow = r_rxUnderflow;

endmodule

// File: tb/tb_io_line_bridge.sv
module tb_io_line_bridge;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         resetN;
    logic [W-1:0] outputLine;
    logic         outputLineWrite;
    logic         inputRead;
    logic [W-1:0] inputLine;
    logic         inputValid;
    logic [W-1:0] txData;
    logic         txValid;
    logic         txReady;
    logic [W-1:0] rxData;
    logic         rxValid;
    logic         rxReady;
    logic         txFull;
    logic         txOverflow;
    logic         rxUnderflow;
    logic         clearErrors;

    int n_chk  = 0;
    int n_pass = 0;
    logic [W-1:0] tx_q[$];
    logic [W-1:0] rx_q[$];

    io_line_bridge #(.DEPTH(4), .WIDTH(W)) dut (
        .clock           (clock),
        .resetN          (resetN),
        .outputLine      (outputLine),
        .outputLineWrite (outputLineWrite),
        .inputRead       (inputRead),
        .inputLine       (inputLine),
        .inputValid      (inputValid),
        .txData          (txData),
        .txValid         (txValid),
        .txReady         (txReady),
        .rxData          (rxData),
        .rxValid         (rxValid),
        .rxReady         (rxReady),
        .txFull          (txFull),
        .txOverflow      (txOverflow),
        .rxUnderflow     (rxUnderflow),
        .clearErrors     (clearErrors)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard: the handshake seen at the falling edge is the one the
    // next rising edge commits.
    always @(negedge clock) begin
        if (resetN) begin
            if (txValid && txReady) begin
                if (tx_q.size() == 0) chk("tx_unexpected", {16'h0, txData}, 32'hFFFF_FFFF);
                else chk("tx_data", {16'h0, txData}, {16'h0, tx_q.pop_front()});
            end
            if (inputValid && inputRead) begin
                if (rx_q.size() == 0) chk("rx_unexpected", {16'h0, inputLine}, 32'hFFFF_FFFF);
                else chk("rx_data", {16'h0, inputLine}, {16'h0, rx_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        outputLineWrite = 0; inputRead = 0; rxValid = 0; clearErrors = 0;
    endtask

    // Drain both directions; an expired budget is a failure.
    task automatic drain();
        int k;
        idle();
        txReady = 1;
        inputRead = inputValid;
        for (k = 0; k < 50; k++) begin
            if (!txValid && !inputValid) break;
            step();
            inputRead = inputValid;
        end
        chk("drain_done", {31'h0, (k < 50)}, 32'h1);
        chk("tx_q_empty", tx_q.size(), 0);
        chk("rx_q_empty", rx_q.size(), 0);
        inputRead = 0;
        txReady = 0;
    endtask

    initial begin
        resetN = 0; idle(); txReady = 0; outputLine = '0; rxData = '0;
        #2;
        chk("rst_txValid", {31'h0, txValid}, 0);
        chk("rst_txData", {16'h0, txData}, 0);
        chk("rst_inputValid", {31'h0, inputValid}, 0);
        chk("rst_inputLine", {16'h0, inputLine}, 0);
        chk("rst_txFull", {31'h0, txFull}, 0);
        chk("rst_rxReady", {31'h0, rxReady}, 1);
        chk("rst_txOverflow", {31'h0, txOverflow}, 0);
        chk("rst_rxUnderflow", {31'h0, rxUnderflow}, 0);
        #10 resetN = 1;
        step();

        // Reset mid-traffic
        outputLineWrite = 1; outputLine = 16'h1111; tx_q.push_back(16'h1111);
        step();
        outputLine = 16'h2222; tx_q.push_back(16'h2222);
        step();
        idle();
        chk("pre_rst_txValid", {31'h0, txValid}, 1);
        #2 resetN = 0;
        #1;
        chk("async_rst_txValid", {31'h0, txValid}, 0);
        chk("async_rst_txData", {16'h0, txData}, 0);
        tx_q.delete();
        #1 resetN = 1;
        step();
        outputLineWrite = 1; outputLine = 16'hABCD; tx_q.push_back(16'hABCD);
        step();
        idle();
        chk("post_rst_txValid", {31'h0, txValid}, 1);
        chk("post_rst_txData", {16'h0, txData}, 32'hABCD);
        drain();

        // TX fill and overflow
        for (int i = 1; i <= 5; i++) begin
            outputLineWrite = 1; outputLine = W'(i);
            if (i <= 4) tx_q.push_back(W'(i));
            step();
            if (i == 3) chk("fill3_txFull", {31'h0, txFull}, 0);
            if (i == 4) chk("fill4_txFull", {31'h0, txFull}, 1);
            if (i == 4) chk("fill4_ovf", {31'h0, txOverflow}, 0);
        end
        idle();
        chk("fill5_ovf", {31'h0, txOverflow}, 1);
        drain();
        chk("drained_txValid", {31'h0, txValid}, 0);
        chk("ovf_sticky", {31'h0, txOverflow}, 1);
        clearErrors = 1;
        step();
        idle();
        chk("ovf_cleared", {31'h0, txOverflow}, 0);

        // Full with simultaneous pop
        for (int i = 0; i < 4; i++) begin
            outputLineWrite = 1; outputLine = W'(16'h10 + i); tx_q.push_back(W'(16'h10 + i));
            step();
        end
        txReady = 1; outputLine = 16'h00FF; tx_q.push_back(16'h00FF);
        step();
        idle(); txReady = 0;
        chk("fullpop_ovf", {31'h0, txOverflow}, 0);
        chk("fullpop_txFull", {31'h0, txFull}, 1);
        drain();
        chk("fullpop_ovf_end", {31'h0, txOverflow}, 0);

        // RX wrap-around, CPU reading every cycle it can
        begin
            int n = 0;
            logic rdy_low = 0;
            for (int c = 0; c < 14; c++) begin
                if (!rxReady) rdy_low = 1;
                rxValid = (n < 10);
                rxData  = W'(16'h0100 + n);
                if (rxValid && rxReady) begin rx_q.push_back(rxData); n++; end
                inputRead = inputValid;
                step();
            end
            idle();
            chk("rx_count", n, 10);
            chk("rx_rdy_never_low", {31'h0, rdy_low}, 0);
            chk("rx_no_udf", {31'h0, rxUnderflow}, 0);
            chk("rx_wrap_q", rx_q.size(), 0);
        end

        // Underflow with simultaneous push into empty FIFO
        inputRead = 1; rxValid = 1; rxData = 16'h5A5A; rx_q.push_back(16'h5A5A);
        step();
        idle();
        chk("udf_set", {31'h0, rxUnderflow}, 1);
        chk("udf_kept_valid", {31'h0, inputValid}, 1);
        chk("udf_kept_data", {16'h0, inputLine}, 32'h5A5A);
        inputRead = 1;
        step();
        idle();
        chk("udf_popped", {31'h0, inputValid}, 0);
        clearErrors = 1; inputRead = 1;
        step();
        idle();
        chk("udf_clear_lost", {31'h0, rxUnderflow}, 1);
        clearErrors = 1;
        step();
        idle();
        chk("udf_cleared", {31'h0, rxUnderflow}, 0);

        // Random mixed traffic
        for (int c = 0; c < 300; c++) begin
            outputLineWrite = !txFull && ($urandom_range(0, 2) != 0);
            outputLine = W'($urandom);
            if (outputLineWrite) tx_q.push_back(outputLine);
            txReady = ($urandom_range(0, 2) != 0);
            rxValid = ($urandom_range(0, 2) != 0);
            rxData = W'($urandom);
            if (rxValid && rxReady) rx_q.push_back(rxData);
            inputRead = inputValid && ($urandom_range(0, 1) != 0);
            step();
        end
        drain();
        chk("rand_no_ovf", {31'h0, txOverflow}, 0);
        chk("rand_no_udf", {31'h0, rxUnderflow}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/io_line_bridge.md
# io_line_bridge

Peripheral end of the CPU's `inputLine`/`outputLine` port pair. It captures each word the CPU drives onto `outputLine` under `outputLineWrite` into a transmit FIFO and drains it to an external sink over valid/ready. It also buffers words from an external source in a receive FIFO and presents the head on `inputLine` for the CPU to consume. It sits between the CPU core and the board-level I/O device, outside the CPU's single-cycle datapath.

## Interface
- `DEPTH`, 4: entries per FIFO; power of two, ≥2.
- `WIDTH`, 16: word width; matches CPU datapath.

- `clock`  in  1  single system clock, rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `outputLine`  in  WIDTH  word from CPU.
- `outputLineWrite`  in  1  CPU write strobe, one word per cycle when high.
- `inputRead`  in  1  CPU consumes `inputLine` this cycle.
- `inputLine`  out  WIDTH  RX FIFO head; 0 when empty.
- `inputValid`  out  1  RX FIFO non-empty.
- `txData`  out  WIDTH  TX FIFO head; 0 when empty.
- `txValid`  out  1  TX FIFO non-empty.
- `txReady`  in  1  sink accepts `txData`.
- `rxData`  in  WIDTH  source word.
- `rxValid`  in  1  source word valid.
- `rxReady`  out  1  RX FIFO not full.
- `txFull`  out  1  TX FIFO full; CPU software polls it before writing.
- `txOverflow`  out  1  sticky: write dropped because the TX FIFO was full.
- `rxUnderflow`  out  1  sticky: `inputRead` asserted while the RX FIFO was empty.
- `clearErrors`  in  1  synchronous clear of both sticky flags.

## Operation
- **TX push:** push `outputLine` when `outputLineWrite && !txFull`.
  - If `outputLineWrite` is high while full, the word is dropped and `txOverflow` is set.
  - Exception: if a pop occurs in the same cycle while full, the push is accepted, the count is unchanged, and no overflow is flagged.
- **TX pop:** occurs on `txValid && txReady`.
  - The TX side follows the standard valid/ready rule: `txData` is held stable while `txValid && !txReady`.
- **RX push:** occurs on `rxValid && rxReady`.
- **RX pop:** occurs on `inputRead && inputValid`.
  - `inputRead` while empty pops nothing and sets `rxUnderflow`. This holds even if a push into the empty FIFO happens in the same cycle; the pushed word is kept.
  - Push and pop in the same cycle on a non-empty FIFO leave the count unchanged.
- **Pointers and count:** each FIFO has read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count of log2(DEPTH)+1 bits ranging 0..DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- **Sticky flags:** if `clearErrors` and a new error event occur in the same cycle, the error wins and the flag stays set.
- **Reset (`resetN` low, any time):** clears pointers, counts, storage and sticky flags immediately. Words in flight are discarded.
  - Output values during and after reset: `txValid`=0, `txData`=0, `inputValid`=0, `inputLine`=0, `txFull`=0, `rxReady`=1, `txOverflow`=0, `rxUnderflow`=0.

## Timing
- All state updates on the rising edge of `clock`.
- All outputs are combinational from registered state only; there is no input-to-output combinational path.
- **TX latency:** a word written at edge N appears on `txData`/`txValid` in the cycle after edge N. Throughput is one word per cycle.
- **RX latency:** a word accepted at edge N appears on `inputLine`/`inputValid` in the cycle after edge N. Throughput is one word per cycle.
- `rxReady` and `txFull` reflect count after the last edge.
  - `rxReady` does not rise in the same cycle as a pop frees space; it rises the cycle after the freeing pop's edge.
- **Reset release:** the first accepting edge is the first rising edge with `resetN` high.

## Structure
- **Package `io_line_pkg`:** holds `WORD_WIDTH` = 16, `DEFAULT_DEPTH` = 4, and a function for the pointer width (clog2 of depth).
- **Sub-module `io_line_fifo`:** a parameterised synchronous FIFO, instantiated twice (TX and RX).
  - Ports: `push`, `pushData`, `pop`, `head`, `empty`, `full`.
  - Implements the full-push-with-pop acceptance rule and the 0-when-empty head.
- **Top level:** holds only the overflow/underflow detection, the sticky flags, and the handshake mapping.

## Test plan
- Reset mid-traffic: fill TX with 0x1111, 0x2222, assert `resetN` low asynchronously → `txValid`=0, `txData`=0 before the next edge. After release, write 0xABCD → `txData`=0xABCD next cycle.
- TX fill/overflow with DEPTH=4, `txReady`=0: write 0x0001–0x0005 on consecutive cycles → `txFull` high after the 4th write, `txOverflow` set by the 5th. Then `txReady`=1 → `txData` shows 0x0001..0x0004 in order, then `txValid`=0.
- Full-with-simultaneous-pop: TX full, `txReady`=1 and write 0x00FF in the same cycle → accepted, `txOverflow` stays 0, and 0x00FF drains 4th.
- RX wrap-around: push 10 words 0x0100+i with `inputRead` pulsed each cycle → `inputLine` sequence exactly 0x0100..0x0109, `rxReady` never low.
- Underflow: RX empty, `inputRead`=1 while pushing 0x5A5A → `rxUnderflow`=1 and 0x5A5A is readable next cycle. `clearErrors` then clears the flag unless another underflow occurs in the same cycle.
